// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported RAM between an instruction-fetch requester and a
// data-stage load/store requester. Data has fixed priority over fetch. Each
// access is registered toward the RAM, waits for ram_arb_ack for at most
// TIMEOUT cycles, and is then reported back to its owner with a one-cycle
// ready pulse. A timed-out access returns zero data and sets a sticky error.
//
// Handshake contract (both requester ports and the RAM port):
//   - A requester raises its request (if_arb_req, or mem_arb_readmem /
//     mem_arb_writemem) together with its address/data and holds them until
//     its ready output pulses. The ready pulse is exactly one cycle wide and
//     the matching rdata output is valid in that cycle and stays stable until
//     the next completion for the same requester.
//   - A request is only considered while the arbiter is idle and while its own
//     ready is low, so a request still held during its ready cycle is never
//     granted twice. Once granted, the requester's inputs are ignored until
//     completion, so dropping or changing them mid-access has no effect.
//   - Toward the RAM, arb_ram_req is held high with stable address/we/wdata
//     for the whole access; the RAM completes it by raising ram_arb_ack for
//     one cycle with ram_arb_rdata valid. An ack seen while idle is ignored.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_arb_req,
  input  logic [31:0] if_arb_addr,
  input  logic        mem_arb_readmem,
  input  logic        mem_arb_writemem,
  input  logic [31:0] mem_arb_addr,
  input  logic [31:0] mem_arb_wdata,
  input  logic        ram_arb_ack,
  input  logic [31:0] ram_arb_rdata,
  output logic        arb_ram_req,
  output logic        arb_ram_we,
  output logic [31:0] arb_ram_addr,
  output logic [31:0] arb_ram_wdata,
  output logic        arb_if_ready,
  output logic [31:0] arb_if_rdata,
  output logic        arb_mem_ready,
  output logic [31:0] arb_mem_rdata,
  output logic        arb_if_stall,
  output logic        arb_mem_stall,
  output logic        arb_err,
  output logic [1:0]  fsm_state
);

  // Counter must reach TIMEOUT-1 without wrapping; keep at least one bit.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DGRANT = 2'd1;
  localparam logic [1:0] FGRANT = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] wait_cnt;

  logic data_req;
  logic data_valid;
  logic fetch_valid;
  logic granted;
  logic done_ack;
  logic done_timeout;
  logic done;

  // A requester is eligible only while its own completion pulse is low.
  assign data_req     = mem_arb_readmem | mem_arb_writemem;
  assign data_valid   = data_req & ~arb_mem_ready;
  assign fetch_valid  = if_arb_req & ~arb_if_ready;

  // Completion of the current access: ack wins over a simultaneous timeout.
  assign granted      = (state == DGRANT) || (state == FGRANT);
  assign done_ack     = granted & ram_arb_ack;
  assign done_timeout = granted & ~ram_arb_ack & (wait_cnt == CNT_LAST);
  assign done         = done_ack | done_timeout;

  // Stalls follow the live request and drop in the ready cycle.
  assign arb_if_stall  = if_arb_req & ~arb_if_ready;
  assign arb_mem_stall = data_req & ~arb_mem_ready;

  assign fsm_state = state;

  // Next-state selection: data beats fetch, grants return to idle on completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (data_valid) begin
          state_next = DGRANT;
        end else if (fetch_valid) begin
          state_next = FGRANT;
        end
      end
      DGRANT, FGRANT: begin
        if (done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter: held at zero while idle, counts grant cycles without ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (!ram_arb_ack && (wait_cnt != CNT_LAST)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // RAM request registers: latched on the grant edge, frozen during the access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arb_ram_req   <= 1'b0;
      arb_ram_we    <= 1'b0;
      arb_ram_addr  <= '0;
      arb_ram_wdata <= '0;
    end else if (state == IDLE) begin
      if (data_valid) begin
        arb_ram_req   <= 1'b1;
        // A simultaneous read+write request is treated as a write.
        arb_ram_we    <= mem_arb_writemem;
        arb_ram_addr  <= mem_arb_addr;
        arb_ram_wdata <= mem_arb_wdata;
      end else if (fetch_valid) begin
        // Fetches never write; wdata keeps the last data-side value.
        arb_ram_req   <= 1'b1;
        arb_ram_we    <= 1'b0;
        arb_ram_addr  <= if_arb_addr;
      end
    end else if (done) begin
      arb_ram_req <= 1'b0;
    end
  end

  // Completion registers: one-cycle ready pulse and returned data per owner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arb_if_ready  <= 1'b0;
      arb_if_rdata  <= '0;
      arb_mem_ready <= 1'b0;
      arb_mem_rdata <= '0;
    end else begin
      arb_if_ready  <= 1'b0;
      arb_mem_ready <= 1'b0;
      if (done && (state == DGRANT)) begin
        arb_mem_ready <= 1'b1;
        // Stores leave the load-data register untouched.
        if (!arb_ram_we) begin
          arb_mem_rdata <= done_ack ? ram_arb_rdata : 32'd0;
        end
      end
      if (done && (state == FGRANT)) begin
        arb_if_ready <= 1'b1;
        arb_if_rdata <= done_ack ? ram_arb_rdata : 32'd0;
      end
    end
  end

  // Sticky error: any timed-out access sets it until the next reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arb_err <= 1'b0;
    end else if (done_timeout) begin
      arb_err <= 1'b1;
    end
  end

endmodule
